// File: rtl/vscpu_core.sv
// Multi-cycle 32-bit memory-to-memory CPU driving a single-port word RAM with 1-cycle read latency.
// state | meaning
// FETCH | present PC to RAM
// DEC   | latch instruction word, present A
// RDA   | latch mem[A] into R1, present B
// EXE   | mem[B] on read data; compute, store or branch
// IND   | second hop of indirect copy: store mem[mem[B]] to A
module vscpu_core #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_fromRAM,
    output logic          wrEn,
    output logic [AW-1:0] addr_toRAM,
    output logic [DW-1:0] data_toRAM
);

    typedef enum logic [2:0] {FETCH, DEC, RDA, EXE, IND} state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_CP   = 3'd4;
    localparam logic [2:0] OP_CPI  = 3'd5;
    localparam logic [2:0] OP_BZJ  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    state_t        state;
    logic [AW-1:0] pc;
    logic [DW-1:0] iw;
    logic [DW-1:0] r1;

    logic [2:0]    op;
    logic          imm;
    logic [AW-1:0] fa;
    logic [AW-1:0] fb;
    logic [DW-1:0] x;
    logic [DW-1:0] result;
    logic          wr_c;

    assign op  = iw[31:29];
    assign imm = iw[28];
    assign fa  = iw[27:14];
    assign fb  = iw[13:0];
    assign x   = imm ? {{(DW-AW){1'b0}}, fb} : data_fromRAM;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = r1 + x;
            OP_NAND: result = ~(r1 & x);
            // shift amounts 32..63 reverse direction; x[4:0] equals x-32 there
            OP_SRL: begin
                if (x < 32)      result = r1 >> x[4:0];
                else if (x < 64) result = r1 << x[4:0];
                else             result = '0;
            end
            OP_LT:   result = {{(DW-1){1'b0}}, (r1 < x)};
            OP_CP:   result = x;
            OP_MUL:  result = r1 * x;
            default: result = '0;
        endcase
    end

    always_comb begin
        wr_c       = 1'b0;
        addr_toRAM = pc;
        data_toRAM = '0;
        case (state)
            FETCH: addr_toRAM = pc;
            DEC:   addr_toRAM = data_fromRAM[27:14];
            RDA:   addr_toRAM = fb;
            EXE: begin
                case (op)
                    OP_BZJ: addr_toRAM = pc;
                    OP_CPI: begin
                        if (imm) begin
                            wr_c       = 1'b1;
                            addr_toRAM = r1[AW-1:0];
                            data_toRAM = data_fromRAM;
                        end else begin
                            addr_toRAM = data_fromRAM[AW-1:0];
                        end
                    end
                    default: begin
                        wr_c       = 1'b1;
                        addr_toRAM = fa;
                        data_toRAM = result;
                    end
                endcase
            end
            IND: begin
                wr_c       = 1'b1;
                addr_toRAM = fa;
                data_toRAM = data_fromRAM;
            end
            default: addr_toRAM = pc;
        endcase
    end

    // a write must never escape while reset is held, even mid-instruction
    assign wrEn = wr_c & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            pc    <= '0;
            iw    <= '0;
            r1    <= '0;
        end else begin
            case (state)
                FETCH: state <= DEC;
                DEC: begin
                    iw    <= data_fromRAM;
                    state <= RDA;
                end
                RDA: begin
                    r1    <= data_fromRAM;
                    state <= EXE;
                end
                EXE: begin
                    state <= FETCH;
                    if (op == OP_BZJ) begin
                        if (imm)                    pc <= r1[AW-1:0] + fb;
                        else if (data_fromRAM == 0) pc <= r1[AW-1:0];
                        else                        pc <= pc + 1'b1;
                    end else if (op == OP_CPI && !imm) begin
                        state <= IND;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                IND: begin
                    pc    <= pc + 1'b1;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vscpu_core.sv
// Directed-vector bench for vscpu_core with a behavioural 16K x 32 RAM.
module tb_vscpu_core;

    logic        clk;
    logic        rst;
    logic [31:0] data_fromRAM;
    logic        wrEn;
    logic [13:0] addr_toRAM;
    logic [31:0] data_toRAM;

    logic [31:0] mem [0:16383];

    int checks;
    int errors;

    vscpu_core dut (
        .clk          (clk),
        .rst          (rst),
        .data_fromRAM (data_fromRAM),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_fromRAM <= mem[addr_toRAM];
        if (wrEn) mem[addr_toRAM] <= data_toRAM;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // hold reset two edges and clear memory; caller loads program then calls go()
    task automatic start_test();
        rst = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic go();
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one-instruction program at address 0 with two operand words at 100/101
    task automatic one_op(input string tag, input logic [31:0] word,
                          input logic [31:0] a_val, input logic [31:0] b_val,
                          input logic [31:0] exp);
        start_test();
        mem[0] = word; mem[100] = a_val; mem[101] = b_val;
        go();
        run(4);
        chk(tag, mem[100], exp);
        chk({tag, "_pc"}, {18'h0, addr_toRAM}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        data_fromRAM = 32'h0;

        start_test();
        chk("rst_addr", {18'h0, addr_toRAM}, 32'd0);
        chk("rst_wren", {31'h0, wrEn}, 32'd0);

        one_op("add",      32'h00190065, 32'd5,        32'd7, 32'd12);
        one_op("add_wrap", 32'h10190001, 32'hFFFFFFFF, 32'd0, 32'd0);
        one_op("nandi",    32'h30190005, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFA);
        one_op("srli_33",  32'h50190021, 32'd3,        32'd0, 32'd6);
        one_op("srli_2",   32'h50190002, 32'h1B20,     32'd0, 32'h6C8);
        one_op("srli_32",  32'h50190020, 32'd3,        32'd0, 32'd3);
        one_op("srli_64",  32'h50190040, 32'hFFFFFFFF, 32'd0, 32'd0);
        one_op("lt_true",  32'h70190007, 32'd5,        32'd0, 32'd1);
        one_op("lt_equal", 32'h70190005, 32'd5,        32'd0, 32'd0);
        one_op("cpi_imm",  32'h90191234, 32'd5,        32'd0, 32'h1234);
        one_op("cp_mem",   32'h80190065, 32'd5,        32'hDEADBEEF, 32'hDEADBEEF);

        // MUL operand from mem[102]
        start_test();
        mem[0] = 32'hE0190066; mem[100] = 32'h1B20; mem[102] = 32'd2;
        go();
        run(4);
        chk("mul", mem[100], 32'h3640);

        // indirect copy takes five clocks
        start_test();
        mem[0] = 32'hA0190065; mem[101] = 32'd120; mem[120] = 32'hE0190066;
        go();
        run(4);
        chk("cpi_early", mem[100], 32'h0);
        run(1);
        chk("cpi", mem[100], 32'hE0190066);
        chk("cpi_pc", {18'h0, addr_toRAM}, 32'd1);

        start_test();
        mem[0] = 32'hB0190065; mem[100] = 32'd120; mem[101] = 32'd1;
        go();
        run(4);
        chk("cpii", mem[120], 32'd1);
        chk("cpii_a", mem[100], 32'd120);

        start_test();
        mem[0] = 32'hC0190065; mem[100] = 32'd40; mem[101] = 32'd0;
        go();
        run(4);
        chk("bzj_taken", {18'h0, addr_toRAM}, 32'd40);

        start_test();
        mem[0] = 32'hC0190065; mem[100] = 32'd40; mem[101] = 32'd1;
        go();
        run(4);
        chk("bzj_not", {18'h0, addr_toRAM}, 32'd1);
        chk("bzj_nowr", mem[100], 32'd40);

        start_test();
        mem[0] = 32'hD0190003; mem[100] = 32'd40;
        go();
        run(4);
        chk("bzji", {18'h0, addr_toRAM}, 32'd43);

        // jump to the top word, then PC must wrap to 0
        start_test();
        mem[0] = 32'hD019000F; mem[100] = 32'h3FF0;
        go();
        run(4);
        chk("jmp_top", {18'h0, addr_toRAM}, 32'h3FFF);
        run(4);
        chk("pc_wrap", {18'h0, addr_toRAM}, 32'd0);

        // self-modifying: CP writes word 1 from word 2, which then increments mem[100]
        start_test();
        mem[0] = 32'h80004002; mem[2] = 32'h10190001; mem[100] = 32'd5;
        go();
        run(4);
        chk("smc_wr", mem[1], 32'h10190001);
        run(4);
        chk("smc_exec", mem[100], 32'd6);

        // reset during EXE aborts the write
        start_test();
        mem[0] = 32'h00190065; mem[100] = 32'd5; mem[101] = 32'd7;
        go();
        run(3);
        rst = 1'b0;
        #1;
        chk("rst_exe_wren", {31'h0, wrEn}, 32'd0);
        run(1);
        chk("rst_exe_mem", mem[100], 32'd5);
        chk("rst_exe_addr", {18'h0, addr_toRAM}, 32'd0);
        rst = 1'b1;
        run(4);
        chk("rst_rerun", mem[100], 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
